// File: rtl/pdm2pcm_pkg.sv
// Shared types and constants for the PDM-to-PCM capture controller.
package pdm2pcm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_RUN
  } capture_state_t;

  typedef enum logic [1:0] {
    LEFT_ONLY  = 2'b00,
    RIGHT_ONLY = 2'b01,
    STEREO     = 2'b10
  } channel_mode_t;

  localparam logic CHANNEL_LEFT  = 1'b0;
  localparam logic CHANNEL_RIGHT = 1'b1;
  localparam int   PCM_W         = 16;

  // Returns {right_enabled, left_enabled}; both encodings 10 and 11 mean stereo.
  function automatic logic [1:0] mode_enables(input logic [1:0] mode);
    if (mode == LEFT_ONLY)       return 2'b01;
    else if (mode == RIGHT_ONLY) return 2'b10;
    else                         return 2'b11;
  endfunction

endpackage

// File: rtl/pdm2pcm_sample_fifo.sv
// First-word fall-through PCM sample FIFO with synchronous flush.
module pdm2pcm_sample_fifo
  import pdm2pcm_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [PCM_W-1:0] data,
  output logic [PCM_W-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [PCM_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a push on full needs.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/pdm2pcm_capture_controller.sv
// PDM capture sequencer: mic clock generation, L/R bit capture into the shared
// pipeline, filter warm-up discard and per-channel PCM FIFOs.
module pdm2pcm_capture_controller
  import pdm2pcm_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int WARMUP_SAMPLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [7:0]       clock_divider_i,
  input  logic [1:0]       channel_mode_i,
  input  logic             clear_i,
  output logic             pdm_clk_o,
  input  logic             pdm_data_i,
  output logic             pipe_clk_en_o,
  output logic             pipe_pdm_o,
  output logic             pipe_valid_o,
  output logic             pipe_channel_o,
  input  logic [PCM_W-1:0] pipe_pcm_i,
  input  logic             pipe_valid_i,
  input  logic             pipe_channel_i,
  input  logic             pipe_invalid_i,
  input  logic             left_read_i,
  input  logic             right_read_i,
  output logic [PCM_W-1:0] left_pcm_o,
  output logic [PCM_W-1:0] right_pcm_o,
  output logic             left_empty_o,
  output logic             right_empty_o,
  output logic             overflow_o,
  output logic             error_o
);
  // state     | meaning
  // ST_IDLE   | pipeline gated off, mic clock parked low, return path ignored
  // ST_WARMUP | clocks running, filter output counted and discarded
  // ST_RUN    | returned PCM samples pushed into the channel FIFOs
  localparam int WW = $clog2(WARMUP_SAMPLES + 1);
  localparam logic [WW-1:0] WARM_DONE = WW'(WARMUP_SAMPLES);

  capture_state_t state, state_nxt;
  logic [7:0]     div_q, cnt;
  logic           en_l, en_r, started;
  logic [WW-1:0]  warm_l, warm_r, warm_l_nxt, warm_r_nxt;
  logic           active, tick, cap_l, cap_r, flush;
  logic           ret_l, ret_r, push_l, push_r, drop_l, drop_r;
  logic           left_full, right_full;

  assign active        = (state != ST_IDLE);
  assign pipe_clk_en_o = active;
  assign tick          = active && (cnt == div_q - 8'd1);
  // The low phase before the first rising edge carries no mic data, so the
  // first capture after enable is always LEFT.
  assign cap_l = tick && enable_i && pdm_clk_o && en_l;
  assign cap_r = tick && enable_i && !pdm_clk_o && started && en_r;

  assign ret_l  = pipe_valid_i && (pipe_channel_i == CHANNEL_LEFT) && en_l;
  assign ret_r  = pipe_valid_i && (pipe_channel_i == CHANNEL_RIGHT) && en_r;
  assign push_l = (state == ST_RUN) && ret_l;
  assign push_r = (state == ST_RUN) && ret_r;
  assign drop_l = push_l && left_full && !(left_read_i && !left_empty_o);
  assign drop_r = push_r && right_full && !(right_read_i && !right_empty_o);
  assign flush  = (state == ST_IDLE) && enable_i;

  always_comb begin
    state_nxt  = state;
    warm_l_nxt = warm_l;
    warm_r_nxt = warm_r;
    unique case (state)
      ST_IDLE: begin
        warm_l_nxt = '0;
        warm_r_nxt = '0;
        if (enable_i) state_nxt = ST_WARMUP;
      end
      ST_WARMUP: begin
        if (ret_l && warm_l != WARM_DONE) warm_l_nxt = warm_l + 1'b1;
        if (ret_r && warm_r != WARM_DONE) warm_r_nxt = warm_r + 1'b1;
        if (!enable_i)
          state_nxt = ST_IDLE;
        else if ((!en_l || warm_l_nxt == WARM_DONE) && (!en_r || warm_r_nxt == WARM_DONE))
          state_nxt = ST_RUN;
      end
      ST_RUN:  if (!enable_i) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= ST_IDLE;
      div_q          <= '0;
      en_l           <= 1'b0;
      en_r           <= 1'b0;
      cnt            <= '0;
      pdm_clk_o      <= 1'b0;
      started        <= 1'b0;
      pipe_pdm_o     <= 1'b0;
      pipe_valid_o   <= 1'b0;
      pipe_channel_o <= 1'b0;
      warm_l         <= '0;
      warm_r         <= '0;
      overflow_o     <= 1'b0;
      error_o        <= 1'b0;
    end else begin
      state        <= state_nxt;
      warm_l       <= warm_l_nxt;
      warm_r       <= warm_r_nxt;
      pipe_valid_o <= cap_l || cap_r;
      if (cap_l || cap_r) begin
        pipe_pdm_o     <= pdm_data_i;
        pipe_channel_o <= cap_r ? CHANNEL_RIGHT : CHANNEL_LEFT;
      end

      if (state == ST_IDLE) begin
        cnt       <= '0;
        pdm_clk_o <= 1'b0;
        started   <= 1'b0;
        if (enable_i) begin
          div_q        <= (clock_divider_i == 8'd0) ? 8'd1 : clock_divider_i;
          {en_r, en_l} <= mode_enables(channel_mode_i);
        end
      end else if (!enable_i) begin
        cnt       <= '0;
        pdm_clk_o <= 1'b0;
        started   <= 1'b0;
      end else if (tick) begin
        cnt       <= '0;
        pdm_clk_o <= !pdm_clk_o;
        if (!pdm_clk_o) started <= 1'b1;
      end else begin
        cnt <= cnt + 8'd1;
      end

      if (drop_l || drop_r) overflow_o <= 1'b1;
      else if (clear_i)     overflow_o <= 1'b0;
      if (pipe_invalid_i && active) error_o <= 1'b1;
      else if (clear_i)             error_o <= 1'b0;
    end
  end

  pdm2pcm_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_left_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (flush),
    .push  (push_l),
    .pop   (left_read_i),
    .data  (pipe_pcm_i),
    .head  (left_pcm_o),
    .empty (left_empty_o),
    .full  (left_full)
  );

  pdm2pcm_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_right_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (flush),
    .push  (push_r),
    .pop   (right_read_i),
    .data  (pipe_pcm_i),
    .head  (right_pcm_o),
    .empty (right_empty_o),
    .full  (right_full)
  );

endmodule

// File: tb/tb_pdm2pcm_capture_controller.sv
// Self-checking bench for pdm2pcm_capture_controller: table-driven clock/capture
// vectors, directed warm-up/FIFO/flag sequences and a randomized return path.
module tb_pdm2pcm_capture_controller;
  localparam int DEPTH = 8;
  localparam int WARM  = 4;
  localparam int CYC   = 28;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic [7:0]  clock_divider_i;
  logic [1:0]  channel_mode_i;
  logic        clear_i;
  logic        pdm_clk_o;
  logic        pdm_data_i;
  logic        pipe_clk_en_o;
  logic        pipe_pdm_o;
  logic        pipe_valid_o;
  logic        pipe_channel_o;
  logic [15:0] pipe_pcm_i;
  logic        pipe_valid_i;
  logic        pipe_channel_i;
  logic        pipe_invalid_i;
  logic        left_read_i;
  logic        right_read_i;
  logic [15:0] left_pcm_o;
  logic [15:0] right_pcm_o;
  logic        left_empty_o;
  logic        right_empty_o;
  logic        overflow_o;
  logic        error_o;

  pdm2pcm_capture_controller #(.FIFO_DEPTH(DEPTH), .WARMUP_SAMPLES(WARM)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .clock_divider_i(clock_divider_i),
    .channel_mode_i(channel_mode_i), .clear_i(clear_i), .pdm_clk_o(pdm_clk_o),
    .pdm_data_i(pdm_data_i), .pipe_clk_en_o(pipe_clk_en_o), .pipe_pdm_o(pipe_pdm_o),
    .pipe_valid_o(pipe_valid_o), .pipe_channel_o(pipe_channel_o), .pipe_pcm_i(pipe_pcm_i),
    .pipe_valid_i(pipe_valid_i), .pipe_channel_i(pipe_channel_i),
    .pipe_invalid_i(pipe_invalid_i), .left_read_i(left_read_i), .right_read_i(right_read_i),
    .left_pcm_o(left_pcm_o), .right_pcm_o(right_pcm_o), .left_empty_o(left_empty_o),
    .right_empty_o(right_empty_o), .overflow_o(overflow_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the return path: queues per channel plus flags.
  logic [15:0] q_l[$], q_r[$];
  bit m_active, m_run, m_en_l, m_en_r, m_ovf, m_err;
  int m_warm_l, m_warm_r;

  function automatic void model_reset();
    q_l.delete(); q_r.delete();
    m_active = 0; m_run = 0; m_en_l = 0; m_en_r = 0; m_ovf = 0; m_err = 0;
    m_warm_l = 0; m_warm_r = 0;
  endfunction

  function automatic void model_edge();
    bit set_ovf = 0;
    if (left_read_i && q_l.size() > 0) void'(q_l.pop_front());
    if (right_read_i && q_r.size() > 0) void'(q_r.pop_front());
    if (m_active && pipe_valid_i) begin
      if (pipe_channel_i == 1'b0 && m_en_l) begin
        if (!m_run) begin
          if (m_warm_l < WARM) m_warm_l++;
        end else if (q_l.size() < DEPTH) q_l.push_back(pipe_pcm_i);
        else set_ovf = 1;
      end else if (pipe_channel_i == 1'b1 && m_en_r) begin
        if (!m_run) begin
          if (m_warm_r < WARM) m_warm_r++;
        end else if (q_r.size() < DEPTH) q_r.push_back(pipe_pcm_i);
        else set_ovf = 1;
      end
    end
    if (set_ovf) m_ovf = 1;
    else if (clear_i) m_ovf = 0;
    if (m_active && pipe_invalid_i) m_err = 1;
    else if (clear_i) m_err = 0;
    if (m_active && !m_run && (!m_en_l || m_warm_l >= WARM) && (!m_en_r || m_warm_r >= WARM))
      m_run = 1;
    if (m_active && !enable_i) begin
      m_active = 0; m_run = 0;
    end else if (!m_active && enable_i) begin
      m_active = 1; m_run = 0;
      q_l.delete(); q_r.delete();
      m_warm_l = 0; m_warm_r = 0;
      m_en_l = (channel_mode_i != 2'b01);
      m_en_r = (channel_mode_i != 2'b00);
    end
  endfunction

  task automatic step();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    check("clk_en", pipe_clk_en_o, m_active);
    check("left_empty", left_empty_o, q_l.size() == 0);
    check("right_empty", right_empty_o, q_r.size() == 0);
    check("left_head", left_pcm_o, q_l.size() > 0 ? q_l[0] : 16'h0);
    check("right_head", right_pcm_o, q_r.size() > 0 ? q_r[0] : 16'h0);
    check("overflow", overflow_o, m_ovf);
    check("error", error_o, m_err);
  endtask

  task automatic zero_inputs();
    enable_i = 0; clock_divider_i = 8'd1; channel_mode_i = 2'b10; clear_i = 0;
    pdm_data_i = 0; pipe_pcm_i = 16'h0; pipe_valid_i = 0; pipe_channel_i = 0;
    pipe_invalid_i = 0; left_read_i = 0; right_read_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    zero_inputs();
    rst_i = 1;
    @(negedge clk_i);
    rst_i = 0;
    model_reset();
  endtask

  task automatic ret(input logic ch, input logic [15:0] pcm);
    pipe_valid_i = 1; pipe_channel_i = ch; pipe_pcm_i = pcm;
    step();
    pipe_valid_i = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pdm_clk"}, pdm_clk_o, 0);
    check({tag, "_clk_en"}, pipe_clk_en_o, 0);
    check({tag, "_pipe_pdm"}, pipe_pdm_o, 0);
    check({tag, "_pipe_valid"}, pipe_valid_o, 0);
    check({tag, "_pipe_ch"}, pipe_channel_o, 0);
    check({tag, "_ovf"}, overflow_o, 0);
    check({tag, "_err"}, error_o, 0);
    check({tag, "_l_empty"}, left_empty_o, 1);
    check({tag, "_r_empty"}, right_empty_o, 1);
    check({tag, "_l_head"}, left_pcm_o, 0);
    check({tag, "_r_head"}, right_pcm_o, 0);
  endtask

  typedef struct {
    logic [7:0] div;
    logic [1:0] mode;
    bit         const_one;
    int         exp_d;
    bit         exp_l;
    bit         exp_r;
  } clk_vec_t;

  clk_vec_t vec[5];
  logic d_hist [CYC];

  initial begin
    vec[0] = '{div: 8'd2, mode: 2'b10, const_one: 0, exp_d: 2, exp_l: 1, exp_r: 1};
    vec[1] = '{div: 8'd0, mode: 2'b00, const_one: 1, exp_d: 1, exp_l: 1, exp_r: 0};
    vec[2] = '{div: 8'd3, mode: 2'b01, const_one: 0, exp_d: 3, exp_l: 0, exp_r: 1};
    vec[3] = '{div: 8'd1, mode: 2'b11, const_one: 0, exp_d: 1, exp_l: 1, exp_r: 1};
    vec[4] = '{div: 8'd5, mode: 2'b10, const_one: 0, exp_d: 5, exp_l: 1, exp_r: 1};

    zero_inputs();
    rst_i = 1;
    model_reset();
    @(negedge clk_i);
    check_reset_values("rst");
    rst_i = 0;
    @(negedge clk_i);
    check_reset_values("idle");

    // Clock generation and capture, one table entry per enable.
    for (int e = 0; e < 5; e++) begin
      clock_divider_i = vec[e].div;
      channel_mode_i  = vec[e].mode;
      enable_i        = 1;
      @(posedge clk_i);
      for (int j = 0; j < CYC; j++) begin
        int  dd, k;
        bit  tk, ph, ev, ech;
        @(negedge clk_i);
        dd = vec[e].exp_d;
        check("clkgen_en", pipe_clk_en_o, 1);
        check("clkgen_pdm_clk", pdm_clk_o, ((j / dd) % 2) == 1);
        k   = j - 1;
        ev  = 0;
        ech = 0;
        if (j >= 1) begin
          tk = ((k + 1) % dd) == 0;
          ph = ((k / dd) % 2) == 1;
          if (tk && ph && vec[e].exp_l) ev = 1;
          if (tk && !ph && k >= dd && vec[e].exp_r) begin ev = 1; ech = 1; end
        end
        check("cap_valid", pipe_valid_o, ev);
        if (ev) begin
          check("cap_channel", pipe_channel_o, ech);
          check("cap_bit", pipe_pdm_o, d_hist[k]);
        end
        d_hist[j]  = vec[e].const_one ? 1'b1 : 1'($urandom_range(0, 1));
        pdm_data_i = d_hist[j];
      end
      enable_i = 0;
      @(negedge clk_i);
      check("off_clk_en", pipe_clk_en_o, 0);
      check("off_pdm_clk", pdm_clk_o, 0);
      check("off_valid", pipe_valid_o, 0);
      @(negedge clk_i);
      check("off_valid2", pipe_valid_o, 0);
    end

    // Warm-up discard then first stored samples, stereo.
    do_reset();
    channel_mode_i = 2'b10;
    enable_i = 1;
    step();
    for (int i = 0; i < WARM; i++) begin
      ret(1'b0, 16'($urandom));
      ret(1'b1, 16'($urandom));
      check("warm_l_empty", left_empty_o, 1);
      check("warm_r_empty", right_empty_o, 1);
    end
    ret(1'b0, 16'h1234);
    check("first_left", left_pcm_o, 16'h1234);
    check("first_r_empty", right_empty_o, 1);
    ret(1'b1, 16'hABCD);
    check("first_right", right_pcm_o, 16'hABCD);

    // Disable mid-RUN: pipeline gated next cycle, FIFO data persists.
    enable_i = 0;
    step();
    check("dis_clk_en", pipe_clk_en_o, 0);
    check("dis_pdm_clk", pdm_clk_o, 0);
    check("dis_valid", pipe_valid_o, 0);
    ret(1'b0, 16'h5555);
    step();
    check("dis_keep_l", left_pcm_o, 16'h1234);
    check("dis_keep_r", right_pcm_o, 16'hABCD);
    left_read_i = 1;
    step();
    left_read_i = 0;
    check("dis_read_empty", left_empty_o, 1);

    // Error flag: ignored while idle, set while active, cleared by clear_i.
    pipe_invalid_i = 1;
    step();
    check("err_idle", error_o, 0);
    pipe_invalid_i = 0;
    enable_i = 1;
    step();
    pipe_invalid_i = 1;
    step();
    pipe_invalid_i = 0;
    check("err_set", error_o, 1);
    clear_i = 1;
    step();
    clear_i = 0;
    check("err_clear", error_o, 0);

    // Overflow boundaries, left only.
    enable_i = 0;
    step();
    channel_mode_i = 2'b00;
    clock_divider_i = 8'd1;
    enable_i = 1;
    step();
    for (int i = 0; i < WARM; i++) ret(1'b0, 16'hFFFF);
    for (int i = 0; i < DEPTH; i++) ret(1'b0, 16'h0100 + 16'(i));
    check("ovf_before", overflow_o, 0);
    ret(1'b0, 16'h0BAD);
    check("ovf_set", overflow_o, 1);
    check("ovf_head", left_pcm_o, 16'h0100);
    clear_i = 1;
    step();
    clear_i = 0;
    check("ovf_clear", overflow_o, 0);
    left_read_i = 1;
    ret(1'b0, 16'h0C00);
    left_read_i = 0;
    check("ovf_rw_full", overflow_o, 0);
    check("ovf_rw_head", left_pcm_o, 16'h0101);
    clear_i = 1;
    ret(1'b0, 16'h0DDD);
    clear_i = 0;
    check("ovf_set_wins", overflow_o, 1);
    clear_i = 1;
    step();
    clear_i = 0;
    check("ovf_clear2", overflow_o, 0);

    // Asynchronous reset between clock edges while running.
    pipe_invalid_i = 1;
    step();
    pipe_invalid_i = 0;
    check("pre_rst_err", error_o, 1);
    #2 rst_i = 1;
    #1 check_reset_values("async");
    @(negedge clk_i);
    rst_i = 0;
    model_reset();
    zero_inputs();

    // Randomized return path with random mode, reads and flag events.
    for (int r = 0; r < 4; r++) begin
      channel_mode_i  = 2'($urandom_range(0, 3));
      clock_divider_i = 8'($urandom_range(0, 4));
      enable_i = 1;
      for (int c = 0; c < 170; c++) begin
        pipe_valid_i   = 1'($urandom_range(0, 1));
        pipe_channel_i = 1'($urandom_range(0, 1));
        pipe_pcm_i     = 16'($urandom);
        left_read_i    = ($urandom_range(0, 2) == 0);
        right_read_i   = ($urandom_range(0, 2) == 0);
        clear_i        = ($urandom_range(0, 15) == 0);
        pipe_invalid_i = ($urandom_range(0, 31) == 0);
        pdm_data_i     = 1'($urandom_range(0, 1));
        if (c == 60) channel_mode_i = 2'($urandom_range(0, 3));
        if (c == 150) enable_i = 0;
        step();
      end
      zero_inputs();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
